// File: rtl/digit_sprite_renderer.sv
// Three-stage sprite compositor in front of the digit ROMs: maps scan position to sprite
// row/col, aligns video/sync/background with ROM latency, and keys out transparent pixels.
module digit_sprite_renderer #(
   parameter int          SPR_W       = 25,
   parameter int          SPR_H       = 30,
   parameter int          SCALE_SHIFT = 0,
   parameter logic [11:0] KEY_COLOR   = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic [3:0]  digit_in,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic [1:0]  sync_in,
   input  logic [11:0] bg_color,
   output logic [4:0]  rom_row,
   output logic [4:0]  rom_col,
   output logic [3:0]  rom_sel,
   input  logic [11:0] rom_color,
   output logic [11:0] rgb_out,
   output logic        video_on_out,
   output logic [1:0]  sync_out
);

   localparam logic [10:0] W_SPAN = 11'(SPR_W << SCALE_SHIFT);
   localparam logic [10:0] H_SPAN = 11'(SPR_H << SCALE_SHIFT);

   logic [3:0]  digit_q;
   logic [9:0]  sx_q, sy_q;
   logic [10:0] px, py, sx, sy, dx, dy;
   logic        hit;

   logic        hit_d1, von_d1, hit_d2, von_d2;
   logic [1:0]  sync_d1, sync_d2;
   logic [11:0] bg_d1, bg_d2;

   // Latched once per frame so a score update never tears mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= 4'hF;
         sx_q    <= '0;
         sy_q    <= '0;
      end else if (frame_start) begin
         digit_q <= digit_in;
         sx_q    <= sprite_x;
         sy_q    <= sprite_y;
      end
   end

   // 11-bit bounds so a sprite hugging the right/bottom edge cannot wrap around to 0.
   assign px = {1'b0, pixel_x};
   assign py = {1'b0, pixel_y};
   assign sx = {1'b0, sx_q};
   assign sy = {1'b0, sy_q};
   assign dx = px - sx;
   assign dy = py - sy;

   assign hit = video_on
              & (px >= sx) & (px < sx + W_SPAN)
              & (py >= sy) & (py < sy + H_SPAN)
              & (digit_q <= 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_row <= '0;
         rom_col <= '0;
         rom_sel <= '0;
         hit_d1  <= 1'b0;
         von_d1  <= 1'b0;
         sync_d1 <= '0;
         bg_d1   <= '0;
      end else begin
         rom_row <= hit ? 5'(dy >> SCALE_SHIFT) : 5'd0;
         rom_col <= hit ? 5'(dx >> SCALE_SHIFT) : 5'd0;
         rom_sel <= digit_q;
         hit_d1  <= hit;
         von_d1  <= video_on;
         sync_d1 <= sync_in;
         bg_d1   <= bg_color;
      end
   end

   // Covers the ROM's registered read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_d2  <= 1'b0;
         von_d2  <= 1'b0;
         sync_d2 <= '0;
         bg_d2   <= '0;
      end else begin
         hit_d2  <= hit_d1;
         von_d2  <= von_d1;
         sync_d2 <= sync_d1;
         bg_d2   <= bg_d1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_out      <= '0;
         video_on_out <= 1'b0;
         sync_out     <= '0;
      end else begin
         if (!von_d2)
            rgb_out <= '0;
         else if (hit_d2 && (rom_color != KEY_COLOR))
            rgb_out <= rom_color;
         else
            rgb_out <= bg_d2;
         video_on_out <= von_d2;
         sync_out     <= sync_d2;
      end
   end

endmodule

// File: doc/digit_sprite_renderer.md
Name: digit_sprite_renderer

Overview:
- Pipelined sprite stage directly upstream of the digit ROMs (25 col x 30 row, 12-bit RGB, one-clock registered read).
- Maps the VGA scan position onto a digit sprite's local row/col, drives ROM addresses and digit select, and aligns video_on, sync and background with the ROM's latency.
- Composites the returned ROM colour over a background colour.
- Position and digit are latched once per frame, so a score change never tears mid-frame.

Parameters:
- SPR_W, 25, sprite width in ROM pixels.
- SPR_H, 30, sprite height in ROM pixels.
- SCALE_SHIFT, 0, on-screen magnification 2^SCALE_SHIFT (legal 0..2).
- KEY_COLOR, 12'hFFF, ROM colour treated as transparent.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank; latch strobe
- digit_in  in  4  digit to show next frame; 0..9 valid, 10..15 means blank
- sprite_x  in  10  left edge of sprite in screen pixels
- sprite_y  in  10  top edge of sprite in screen pixels
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- video_on  in  1  active-display flag
- sync_in  in  2  {vsync,hsync} from the VGA timing block
- bg_color  in  12  colour drawn where the sprite is absent or transparent
- rom_row  out  5  ROM row address, 0..29
- rom_col  out  5  ROM column address, 0..24
- rom_sel  out  4  selects which digit ROM's color_data feeds rom_color
- rom_color  in  12  color_data from the selected ROM, valid one clock after address
- rgb_out  out  12  composited pixel
- video_on_out  out  1  video_on delayed to match rgb_out
- sync_out  out  2  sync_in delayed to match rgb_out

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pipeline registers and outputs clear to 0;
  - latched digit resets to 4'hF (blank);
  - latched position resets to 0.
- Frame latch:
  - on a clock with frame_start=1, capture digit_in, sprite_x and sprite_y into the latch registers;
  - otherwise the latches hold;
  - pixels sampled in that same cycle use the old latch values.
- Stage 1 (edge k, sampling pixel_x/pixel_y):
  - dx = pixel_x - sx_q and dy = pixel_y - sy_q, both computed at 11 bits;
  - hit = video_on & (pixel_x >= sx_q) & (pixel_x < sx_q + (SPR_W<<SCALE_SHIFT)) & (pixel_y >= sy_q) & (pixel_y < sy_q + (SPR_H<<SCALE_SHIFT)) & (digit_q <= 9);
  - bounds are compared at 11 bits, so a sprite near the right or bottom edge never wraps;
  - rom_col <= hit ? dx>>SCALE_SHIFT : 0;
  - rom_row <= hit ? dy>>SCALE_SHIFT : 0;
  - rom_sel <= digit_q;
  - hit, video_on, sync_in and bg_color are registered as the _d1 copies.
- Stage 2 (edge k+1):
  - the ROM registers rom_color;
  - the block shifts hit, video_on, sync and bg to the _d2 copies.
- Stage 3 (edge k+2):
  - rgb_out <= !video_on_d2 ? 0 : (hit_d2 & rom_color != KEY_COLOR) ? rom_color : bg_d2;
  - video_on_out <= video_on_d2;
  - sync_out <= sync_d2.
- Latency:
  - the pixel sampled at edge k appears on rgb_out, video_on_out and sync_out after edge k+2, i.e. 3 registered stages;
  - full throughput, one pixel per clock, no stalls.
- Boundaries:
  - first/last sprite pixel: (sx_q, sy_q) gives row 0, col 0;
  - (sx_q + (25<<S) - 1, sy_q + (30<<S) - 1) gives row 29, col 24;
  - one pixel further in x or y gives hit=0;
  - a blank digit (10..15) gives bg everywhere while still driving rom_sel;
  - video_on=0 inside the sprite window gives rgb_out 0.
- Reset mid-frame:
  - outputs go to 0 immediately and the digit goes blank;
  - normal output resumes 3 clocks after release;
  - the digit appears only after the next frame_start.

Test Plan:
1. Reset release, no frame_start, scan the full sprite window with video_on=1 and bg=12'h00F -> rgb_out constant 12'h00F, rom_row/rom_col 0.
2. frame_start with digit_in=9 and sprite (100,50), SCALE_SHIFT=0; pixel (100,50) at edge k -> rom_row=0, rom_col=0 after edge k; rgb_out = ROM value after edge k+2; video_on_out and sync_out match the inputs delayed 3 clocks.
3. Pixels (124,79), (125,79) and (124,80) -> rom_row/rom_col (29,24) with hit for the first; no hit and rgb_out=bg for the other two.
4. Transparency: the ROM model returns 12'hFFF at the hit pixel -> rgb_out=bg; it returns 12'h000 -> rgb_out=12'h000. Also change digit_in to 3 mid-frame without frame_start -> rom_sel stays 9 until the next frame_start.
5. SCALE_SHIFT=1, sprite at (600,460): pixel (649,519) -> row 29, col 24; pixel (650,519) -> no hit; no 10-bit wrap occurs.
6. Assert rst_n low mid-sprite -> rgb_out, sync_out and video_on_out become 0 asynchronously; after release the sprite stays blank until frame_start.
